// File: rtl/match_run_qualifier_pkg.sv
// match_pkg: FSM state type and default parameters shared by match_run_qualifier and the compare-stage bench
package match_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIRE, HOLD} match_state_t;
  localparam int RUN_LEN_DEF = 3;
  localparam int HOLDOFF_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/match_run_qualifier_if.sv
// match_run_qualifier_if: match flag in, event valid/ready/seq out, busy status; slave = qualifier, master = source/consumer
interface match_run_qualifier_if #(parameter int CNT_W = 8);
  logic q_in;
  logic evt_valid;
  logic evt_ready;
  logic [CNT_W-1:0] evt_seq;
  logic busy;
  modport slave (input q_in, input evt_ready, output evt_valid, output evt_seq, output busy);
  modport master (output q_in, output evt_ready, input evt_valid, input evt_seq, input busy);
endinterface

// File: rtl/match_run_qualifier.sv
// match_run_qualifier: fires one event after RUN_LEN consecutive q_in highs, then holds off; ports clk, rst, bus(slave: q_in, evt_ready in; evt_valid, evt_seq, busy out)
module match_run_qualifier
  import match_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  match_run_qualifier_if.slave bus
);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int HW = HOLDOFF == 0 ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [RW-1:0] L_LAST = RW'(RUN_LEN - 1);
  localparam logic [HW-1:0] L_HOLD = HW'(HOLDOFF);
  match_state_t r_state, w_state;
  logic [RW-1:0] r_run, w_run;
  logic [HW-1:0] r_hold, w_hold;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_run <= '0;
      r_hold <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_run <= w_run;
      r_hold <= w_hold;
      r_cnt <= w_cnt;
    end
  end
  always_comb begin
    w_state = r_state;
    w_run = r_run;
    w_hold = r_hold;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (bus.q_in) begin
        w_state = RUN_LEN == 1 ? FIRE : RUN;
        w_run = RUN_LEN == 1 ? '0 : RW'(1);
      end
      RUN: begin
        w_state = !bus.q_in ? IDLE : r_run == L_LAST ? FIRE : RUN;
        w_run = bus.q_in && r_run != L_LAST ? r_run + 1'b1 : '0;
      end
      FIRE: if (bus.evt_ready) begin
        w_state = HOLDOFF == 0 ? IDLE : HOLD;
        w_hold = L_HOLD;
        w_cnt = &r_cnt ? r_cnt : r_cnt + 1'b1;
      end
      HOLD: begin
        w_state = r_hold == HW'(1) ? IDLE : HOLD;
        w_hold = r_hold - 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end
  assign bus.evt_valid = r_state == FIRE;
  assign bus.busy = r_state == FIRE || r_state == HOLD;
  assign bus.evt_seq = r_cnt;
endmodule
